uart_alu_ctrl: RTL and testbench

//  Sequencer between the UART receiver/transmitter pair and the ALU.

---
 rtl/uart_alu_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// ---------------------------------------------------------------------------
// uart_alu_ctrl
//
// Sequencer sitting between a UART receiver/transmitter pair and an ALU.
// Three received bytes (operand A, operand B, opcode) are collected into
// shadow registers. The complete command is then presented to the ALU in a
// single cycle. The ALU result is captured and handed to the transmitter as
// one byte. A partially received command is discarded when the gap between
// two of its bytes grows too long.
//
// Ports
//   i_clock       system clock
//   i_reset       synchronous, active-high reset
//   i_rx_data     byte from the UART receiver, valid while i_rx_done=1
//   i_rx_done     one-cycle pulse, new byte available on i_rx_data
//   i_tx_done     one-cycle pulse, transmitter finished the current byte
//   i_alu_result  combinational ALU result for o_alu_a/o_alu_b/o_alu_op
//   o_alu_a       registered operand A to the ALU
//   o_alu_b       registered operand B to the ALU
//   o_alu_op      registered opcode to the ALU
//   o_tx_data     byte for the transmitter, held until the next capture
//   o_tx_start    one-cycle start request to the transmitter
//   o_busy        high while a command is executing or being transmitted
//   o_timeout     one-cycle pulse, a partial command was discarded
//   o_overrun     one-cycle pulse, a byte arrived while busy and was dropped
// ---------------------------------------------------------------------------
module uart_alu_ctrl #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP      = 6,
  parameter int NB_TIMEOUT = 16,
  parameter int TIMEOUT    = 50000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_LATCH   = 3'd4,
    ST_SEND    = 3'd5,
    ST_WAIT_TX = 3'd6
  } state_t;

  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT - 1);

  state_t                 state;
  state_t                 state_next;
  logic [NB_DATA-1:0]     shadow_a;
  logic [NB_DATA-1:0]     shadow_b;
  logic [NB_OP-1:0]       shadow_op;
  logic [NB_TIMEOUT-1:0]  timeout_count;
  logic [NB_TIMEOUT-1:0]  timeout_count_next;
  logic                   waiting_byte;
  logic                   expired;
  logic                   busy_state;

  // A byte arriving on the expiry cycle wins over the timeout, so expiry
  // only counts when no byte is present.
  assign waiting_byte = (state == ST_GET_B) || (state == ST_GET_OP);
  assign expired      = waiting_byte && !i_rx_done && (timeout_count == TIMEOUT_LAST);
  assign busy_state   = (state == ST_EXEC) || (state == ST_LATCH) ||
                        (state == ST_SEND) || (state == ST_WAIT_TX);

  assign o_tx_start = (state == ST_SEND);
  assign o_busy     = busy_state;

  // Next-state logic. The counter only runs while the FSM stays in one of
  // the byte-waiting states; any state change clears it. This gives a clean
  // zero on entry to GET_B/GET_OP, and the expiry exit stops it before it
  // could wrap.
  always_comb begin
    state_next         = state;
    timeout_count_next = '0;
    case (state)
      ST_IDLE:    if (i_rx_done) state_next = ST_GET_B;
      ST_GET_B: begin
        if (i_rx_done)    state_next = ST_GET_OP;
        else if (expired) state_next = ST_IDLE;
      end
      ST_GET_OP: begin
        if (i_rx_done)    state_next = ST_EXEC;
        else if (expired) state_next = ST_IDLE;
      end
      ST_EXEC:    state_next = ST_LATCH;
      ST_LATCH:   state_next = ST_SEND;
      ST_SEND:    state_next = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (waiting_byte && (state_next == state))
      timeout_count_next = timeout_count + 1'b1;
  end

  // State and timeout counter registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      timeout_count <= '0;
    end else begin
      state         <= state_next;
      timeout_count <= timeout_count_next;
    end
  end

  // Datapath. Bytes go into shadow registers first, so the ALU inputs only
  // ever change together in EXEC and never show a half-received command.
  // A timed-out command leaves stale shadows behind. They are harmless
  // because the next command overwrites all three before EXEC.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shadow_a  <= '0;
      shadow_b  <= '0;
      shadow_op <= '0;
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
      o_timeout <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_timeout <= expired;
      o_overrun <= i_rx_done && busy_state;
      if (i_rx_done) begin
        case (state)
          ST_IDLE:   shadow_a  <= i_rx_data;
          ST_GET_B:  shadow_b  <= i_rx_data;
          ST_GET_OP: shadow_op <= i_rx_data[NB_OP-1:0];
          default:   ;
        endcase
      end
      if (state == ST_EXEC) begin
        o_alu_a  <= shadow_a;
        o_alu_b  <= shadow_b;
        o_alu_op <= shadow_op;
      end
      if (state == ST_LATCH)
        o_tx_data <= i_alu_result;
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_alu_ctrl
//
// Directed testbench for uart_alu_ctrl with a short inter-byte timeout.
// A small ALU stub supports two opcodes: 0x20 returns A+B and 0x22 returns
// A-B. Expected values are written out by hand next to each vector.
// ---------------------------------------------------------------------------
module tb_uart_alu_ctrl;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TIMEOUT = 8;

  logic               i_clock;
  logic               i_reset;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_timeout;
  logic               o_overrun;

  int n_checks = 0;
  int n_errors = 0;
  int tx_start_seen = 0;
  int timeout_seen  = 0;
  int overrun_seen  = 0;
  int snap;

  uart_alu_ctrl #(
    .NB_DATA    (NB_DATA),
    .NB_OP      (NB_OP),
    .NB_TIMEOUT (16),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_tx_done    (i_tx_done),
    .i_alu_result (i_alu_result),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout),
    .o_overrun    (o_overrun)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // ALU stub: add and subtract only.
  always_comb begin
    i_alu_result = '0;
    case (o_alu_op)
      6'h20:   i_alu_result = o_alu_a + o_alu_b;
      6'h22:   i_alu_result = o_alu_a - o_alu_b;
      default: i_alu_result = '0;
    endcase
  end

  // Pulse counters, used to show how many pulses occurred over a stretch.
  always @(posedge i_clock) begin
    if (o_tx_start) tx_start_seen <= tx_start_seen + 1;
    if (o_timeout)  timeout_seen  <= timeout_seen + 1;
    if (o_overrun)  overrun_seen  <= overrun_seen + 1;
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One received byte: i_rx_done is high for exactly one clock edge.
  task automatic applyStimulus(input logic [7:0] data);
    i_rx_data = data;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_alu_a"},   32'(o_alu_a),    32'h0);
    checkOutput({tag, "_alu_b"},   32'(o_alu_b),    32'h0);
    checkOutput({tag, "_alu_op"},  32'(o_alu_op),   32'h0);
    checkOutput({tag, "_tx_data"}, 32'(o_tx_data),  32'h0);
    checkOutput({tag, "_tx_start"},32'(o_tx_start), 32'h0);
    checkOutput({tag, "_busy"},    32'(o_busy),     32'h0);
    checkOutput({tag, "_timeout"}, 32'(o_timeout),  32'h0);
    checkOutput({tag, "_overrun"}, 32'(o_overrun),  32'h0);
  endtask

  // Called right after the edge that accepted the opcode (state EXEC).
  // EXEC -> LATCH loads the ALU inputs; LATCH -> SEND captures the result
  // and raises o_tx_start. With release_tx set, i_tx_done comes 10 cycles
  // after the start pulse; otherwise the FSM is left waiting in WAIT_TX.
  task automatic finishCommand(input string tag, input logic [7:0] a,
                               input logic [7:0] b, input logic [5:0] op,
                               input logic [7:0] result, input bit release_tx);
    checkOutput({tag, "_busy_exec"},  32'(o_busy),     32'h1);
    checkOutput({tag, "_start_exec"}, 32'(o_tx_start), 32'h0);
    tick();
    checkOutput({tag, "_alu_a"},  32'(o_alu_a),  32'(a));
    checkOutput({tag, "_alu_b"},  32'(o_alu_b),  32'(b));
    checkOutput({tag, "_alu_op"}, 32'(o_alu_op), 32'(op));
    checkOutput({tag, "_start_latch"}, 32'(o_tx_start), 32'h0);
    tick();
    checkOutput({tag, "_start_send"}, 32'(o_tx_start), 32'h1);
    checkOutput({tag, "_tx_data"},    32'(o_tx_data),  32'(result));
    tick();
    checkOutput({tag, "_start_wait"}, 32'(o_tx_start), 32'h0);
    checkOutput({tag, "_busy_wait"},  32'(o_busy),     32'h1);
    if (release_tx) begin
      repeat (9) tick();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      checkOutput({tag, "_busy_done"}, 32'(o_busy), 32'h0);
    end
  endtask

  task automatic runCommand(input string tag, input logic [7:0] a,
                            input logic [7:0] b, input logic [5:0] op,
                            input logic [7:0] result, input bit release_tx);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus({2'b00, op});
    finishCommand(tag, a, b, op, result, release_tx);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset   = 1'b1;
    i_rx_data = '0;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    checkAllZero("reset");

    // T1 basic op: 5 + 3 = 8, exactly one start pulse.
    $display("[TB] T1 basic op");
    snap = tx_start_seen;
    runCommand("t1", 8'h05, 8'h03, 6'h20, 8'h08, 1'b1);
    checkOutput("t1_one_start", 32'(tx_start_seen - snap), 32'd1);

    // T2 timeout: one byte then silence for TIMEOUT cycles.
    $display("[TB] T2 timeout");
    doReset();
    applyStimulus(8'h11);
    repeat (TIMEOUT - 1) tick();
    checkOutput("t2_no_early_timeout", 32'(o_timeout), 32'h0);
    tick();
    checkOutput("t2_timeout_pulse", 32'(o_timeout), 32'h1);
    checkOutput("t2_alu_a_untouched", 32'(o_alu_a), 32'h0);
    checkOutput("t2_busy", 32'(o_busy), 32'h0);
    tick();
    checkOutput("t2_timeout_one_cycle", 32'(o_timeout), 32'h0);
    runCommand("t2", 8'h01, 8'h02, 6'h20, 8'h03, 1'b1);

    // T3 boundary: second byte lands exactly when the counter reads 7.
    $display("[TB] T3 timeout boundary");
    snap = timeout_seen;
    applyStimulus(8'h04);
    repeat (TIMEOUT - 1) tick();
    applyStimulus(8'h06);
    checkOutput("t3_no_timeout_pulse", 32'(o_timeout), 32'h0);
    applyStimulus(8'h20);
    finishCommand("t3", 8'h04, 8'h06, 6'h20, 8'h0A, 1'b1);
    checkOutput("t3_timeout_count", 32'(timeout_seen - snap), 32'd0);

    // T4 overrun: a 4th byte straight after the opcode (EXEC), another
    // during WAIT_TX, then one coinciding with the WAIT_TX -> IDLE edge.
    $display("[TB] T4 overrun");
    snap = tx_start_seen;
    applyStimulus(8'h07);
    applyStimulus(8'h08);
    applyStimulus(8'h20);
    applyStimulus(8'h55);
    checkOutput("t4_overrun_exec", 32'(o_overrun), 32'h1);
    tick();
    checkOutput("t4_overrun_one_cycle", 32'(o_overrun), 32'h0);
    checkOutput("t4_start", 32'(o_tx_start), 32'h1);
    checkOutput("t4_tx_data", 32'(o_tx_data), 32'h0F);
    tick();
    applyStimulus(8'h66);
    checkOutput("t4_overrun_wait", 32'(o_overrun), 32'h1);
    checkOutput("t4_busy_after_overrun", 32'(o_busy), 32'h1);
    i_rx_data = 8'hAA;
    i_rx_done = 1'b1;
    i_tx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    checkOutput("t4_overrun_release", 32'(o_overrun), 32'h1);
    checkOutput("t4_busy_release", 32'(o_busy), 32'h0);
    checkOutput("t4_single_start", 32'(tx_start_seen - snap), 32'd1);
    runCommand("t4_next", 8'h09, 8'h04, 6'h20, 8'h0D, 1'b1);

    // T5 reset in GET_OP, then reset in WAIT_TX.
    $display("[TB] T5 reset mid-op");
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    doReset();
    checkAllZero("t5_getop");
    snap = tx_start_seen;
    repeat (5) tick();
    checkOutput("t5_getop_no_start", 32'(tx_start_seen - snap), 32'd0);
    runCommand("t5_cmd", 8'h03, 8'h03, 6'h20, 8'h06, 1'b0);
    doReset();
    checkAllZero("t5_waittx");
    snap = tx_start_seen;
    repeat (12) tick();
    checkOutput("t5_waittx_no_start", 32'(tx_start_seen - snap), 32'd0);
    checkOutput("t5_waittx_idle", 32'(o_busy), 32'h0);

    // T6 back-to-back commands, the second starting right after i_tx_done.
    $display("[TB] T6 back-to-back");
    snap = tx_start_seen;
    runCommand("t6_first",  8'h20, 8'h10, 6'h20, 8'h30, 1'b1);
    runCommand("t6_second", 8'h40, 8'h01, 6'h22, 8'h3F, 1'b1);
    checkOutput("t6_two_starts", 32'(tx_start_seen - snap), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
